// File: rtl/lcd_frame_capture.sv
// LCD frame capture: packs 2-bit raster pixels four per byte
// and writes a full frame into a framebuffer write port.
module lcd_frame_capture #(
    parameter int LCD_LINEWIDTH = 160,
    parameter int LCD_LINES     = 144,
    parameter int PIXEL_BITS    = 2,
    parameter int ADDR_W        = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    pix_valid,
    input  logic [PIXEL_BITS-1:0]   pix_data,
    input  logic                    pix_first,
    output logic                    pix_ready,
    output logic                    fb_we,
    output logic [ADDR_W-1:0]       fb_addr,
    output logic [4*PIXEL_BITS-1:0] fb_wdata,
    input  logic                    fb_ready,
    output logic                    frame_done,
    output logic [7:0]              frame_count,
    output logic                    err_sync,
    input  logic                    err_clr,
    output logic                    busy
);

    localparam int XW = $clog2(LCD_LINEWIDTH);
    localparam int YW = (LCD_LINES > 1) ? $clog2(LCD_LINES) : 1;
    localparam logic [XW-1:0]     X_LAST = XW'(LCD_LINEWIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(LCD_LINES - 1);
    localparam logic [ADDR_W-1:0] BPL    = ADDR_W'(LCD_LINEWIDTH / 4);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t                    state, state_n;
    logic [XW-1:0]             x, px;
    logic [YW-1:0]             y, py;
    logic [3*PIXEL_BITS-1:0]   pack;
    logic                      accept, fb_hs;
    logic                      cap, restart, err_set, byte_full;

    // A stalled write blocks the pixel stream; otherwise always accept
    assign pix_ready = !(fb_we && !fb_ready);
    assign accept    = pix_valid && pix_ready;
    assign fb_hs     = fb_we && fb_ready;
    assign busy      = (state == CAPTURE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and pixel capture decode
    always_comb begin
        state_n   = state;
        cap       = 1'b0;
        restart   = 1'b0;
        err_set   = 1'b0;
        px        = x;
        py        = y;
        unique case (state)
            IDLE: begin
                if (enable && accept && pix_first) begin
                    state_n = CAPTURE;
                    cap     = 1'b1;
                    restart = 1'b1;
                end
            end
            CAPTURE: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (accept) begin
                    cap = 1'b1;
                    if (pix_first) begin
                        restart = 1'b1;
                        err_set = (x != '0) || (y != '0);
                    end else if (x == X_LAST && y == Y_LAST) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (fb_hs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (restart) begin
            px = '0;
            py = '0;
        end
        byte_full = cap && (px[1:0] == 2'b11);
    end

    // Counters, pack register, write port and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            pack        <= '0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_sync    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (fb_hs) fb_we <= 1'b0;
            if (cap) begin
                if (restart)
                    pack <= {{(2*PIXEL_BITS){1'b0}}, pix_data};
                else
                    pack <= {pack[2*PIXEL_BITS-1:0], pix_data};
                if (byte_full) begin
                    fb_we    <= 1'b1;
                    fb_addr  <= ADDR_W'(py) * BPL + ADDR_W'(px >> 2);
                    fb_wdata <= {pack, pix_data};
                end
                if (px == X_LAST) begin
                    x <= '0;
                    y <= (py == Y_LAST) ? '0 : py + 1'b1;
                end else begin
                    x <= px + 1'b1;
                    y <= py;
                end
            end else if (state == CAPTURE && !enable) begin
                x    <= '0;
                y    <= '0;
                pack <= '0;
            end
            if (state == DONE && fb_hs) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 1'b1;
            end
            if (err_set)      err_sync <= 1'b1;
            else if (err_clr) err_sync <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Scoreboard bench for lcd_frame_capture: full-size instance
// for frame/stall/error/abort cases, small instance for wrap.
module tb_lcd_frame_capture;

    localparam int LW = 160;
    localparam int LN = 144;
    localparam int BPL = 40;
    localparam int NPIX = LW * LN;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, pix_valid, pix_first, fb_ready, err_clr;
    logic [1:0]  pix_data;
    logic        pix_ready, fb_we, frame_done, err_sync, busy;
    logic [12:0] fb_addr;
    logic [7:0]  fb_wdata, frame_count;

    logic        s_en, s_valid, s_first, s_fb_ready, s_clr;
    logic [1:0]  s_data;
    logic        s_ready, s_we, s_done, s_err, s_busy;
    logic [12:0] s_addr;
    logic [7:0]  s_wdata, s_fc;

    int pass_cnt = 0;
    int total = 0;
    int s_pulses = 0;
    int exp_fc = 0;
    logic [20:0] exp_q[$];
    logic [7:0]  done_q[$];

    always #5 clk = ~clk;

    lcd_frame_capture dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_first(pix_first), .pix_ready(pix_ready),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .fb_ready(fb_ready), .frame_done(frame_done),
        .frame_count(frame_count), .err_sync(err_sync),
        .err_clr(err_clr), .busy(busy)
    );

    lcd_frame_capture #(.LCD_LINEWIDTH(4), .LCD_LINES(2)) u_small (
        .clk(clk), .rst(rst), .enable(s_en),
        .pix_valid(s_valid), .pix_data(s_data),
        .pix_first(s_first), .pix_ready(s_ready),
        .fb_we(s_we), .fb_addr(s_addr), .fb_wdata(s_wdata),
        .fb_ready(s_fb_ready), .frame_done(s_done),
        .frame_count(s_fc), .err_sync(s_err),
        .err_clr(s_clr), .busy(s_busy)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [1:0] pix(input int x, input int y);
        return 2'((x + y) % 4);
    endfunction

    // Monitor: pop expected writes / frame completions on handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (fb_we && fb_ready) begin
                if (exp_q.size() == 0) chk("unexpected_write", {fb_addr, fb_wdata}, 0);
                else chk("write", {fb_addr, fb_wdata}, exp_q.pop_front());
            end
            if (frame_done) begin
                if (done_q.size() == 0) chk("unexpected_frame_done", frame_count, 999);
                else chk("frame_done_count", frame_count, done_q.pop_front());
            end
            if (s_done) s_pulses++;
        end
    end

    task automatic send(input logic [1:0] d, input logic f);
        int  k;
        bit  acc;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_first = f;
        k   = 0;
        acc = 1'b0;
        while (!acc && k < 100) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!acc) chk("pixel_accept_timeout", 0, 1);
    endtask

    task automatic do_stall();
        fb_ready  = 1'b0;
        pix_valid = 1'b1;
        pix_data  = pix(12, 0);
        pix_first = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0 || j == 9) begin
                chk("stall_we", fb_we, 1);
                chk("stall_addr", fb_addr, 2);
                chk("stall_data", fb_wdata, 8'h1B);
                chk("stall_pix_ready", pix_ready, 0);
            end
            @(posedge clk);
            #1;
        end
        fb_ready = 1'b1;
    endtask

    task automatic stream(input int n, input bit push, input int stall_idx,
                          input bit clr_first);
        int x, y;
        logic [1:0] d;
        for (int i = 0; i < n; i++) begin
            x = i % LW;
            y = i / LW;
            d = pix(x, y);
            if (i == 0 && clr_first) err_clr = 1'b1;
            send(d, i == 0);
            err_clr = 1'b0;
            if (push && x % 4 == 3)
                exp_q.push_back({13'(y * BPL + x / 4),
                                 pix(x - 3, y), pix(x - 2, y), pix(x - 1, y), d});
            if (i == stall_idx) do_stall();
        end
        pix_valid = 1'b0;
        pix_first = 1'b0;
        if (push && n == NPIX) begin
            exp_fc++;
            done_q.push_back(8'(exp_fc));
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b1; pix_valid = 1'b0; pix_first = 1'b0;
        pix_data = 2'd0; fb_ready = 1'b1; err_clr = 1'b0;
        s_en = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_data = 2'd0;
        s_fb_ready = 1'b1; s_clr = 1'b0;
        #3;
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_wdata", fb_wdata, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_err_sync", err_sync, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pix_ready", pix_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Pixels without a frame start are drained silently
        for (int i = 0; i < 50; i++) send(2'(i), 1'b0);
        pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_err_sync", err_sync, 0);
        chk("idle_no_writes", exp_q.size(), 0);

        // One clean full frame
        stream(NPIX, 1'b1, -1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("frame1_count", frame_count, 1);
        chk("frame1_busy", busy, 0);

        // Stall at third write, then abort mid-line 70
        stream(70 * LW + 80, 1'b1, 11, 1'b0);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_count", frame_count, 1);
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Resync: pix_first at (6,2) with err_clr in the same cycle
        stream(2 * LW + 6, 1'b1, -1, 1'b0);
        stream(NPIX, 1'b1, -1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("resync_err_sync", err_sync, 1);
        chk("resync_count", frame_count, 2);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("err_clr", err_sync, 0);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);

        // Reset while a write is stalled drops it
        stream(4, 1'b0, -1, 1'b0);
        fb_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_we", fb_we, 1);
        rst = 1'b1;
        #1;
        chk("rst_stall_we", fb_we, 0);
        chk("rst_stall_busy", busy, 0);
        chk("rst_stall_count", frame_count, 0);
        fb_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        s_pulses = 0;

        // Small instance: 256 frames wrap frame_count
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 8; i++) begin
                s_valid = 1'b1;
                s_data  = 2'(i);
                s_first = (i == 0);
                @(posedge clk); #1;
            end
            s_valid = 1'b0;
            s_first = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            if (f == 254) chk("small_count_255", s_fc, 255);
        end
        chk("small_pulses", s_pulses, 256);
        chk("small_wrap", s_fc, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
